// File: rtl/bus_transfer_controller_pkg.sv
// Shared definitions for the register-bus transfer controller:
// default geometry, FSM state encoding and the released-bus enable pattern.
package bus_transfer_controller_pkg;

  localparam int unsigned DEF_NUM_REGS   = 8;
  localparam int unsigned DEF_SEL_WIDTH  = 3;
  localparam int unsigned DEF_FIFO_DEPTH = 4;
  localparam int unsigned DEF_PTR_WIDTH  = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_LATCH = 2'd2
  } xfer_state_t;

  localparam logic [DEF_NUM_REGS-1:0] BUS_EN_IDLE = '1;

endpackage

// File: rtl/bus_transfer_controller_if.sv
// Request handshake plus per-register active-low bus enables and status pulses.
interface bus_transfer_controller_if
  import bus_transfer_controller_pkg::*;
#(
  parameter int unsigned NUM_REGS  = DEF_NUM_REGS,
  parameter int unsigned SEL_WIDTH = DEF_SEL_WIDTH
);

  logic                 i_REQ_VALID;
  logic                 o_REQ_READY;
  logic [SEL_WIDTH-1:0] i_REQ_SRC;
  logic [SEL_WIDTH-1:0] i_REQ_DST;
  logic [NUM_REGS-1:0]  o_WRITE_BUS_n;
  logic [NUM_REGS-1:0]  o_READ_BUS_n;
  logic                 o_BUSY;
  logic                 o_DONE;
  logic                 o_ERROR;

  modport slave (
    input  i_REQ_VALID, i_REQ_SRC, i_REQ_DST,
    output o_REQ_READY, o_WRITE_BUS_n, o_READ_BUS_n, o_BUSY, o_DONE, o_ERROR
  );

  modport master (
    output i_REQ_VALID, i_REQ_SRC, i_REQ_DST,
    input  o_REQ_READY, o_WRITE_BUS_n, o_READ_BUS_n, o_BUSY, o_DONE, o_ERROR
  );

endinterface

// File: rtl/bus_transfer_controller_req_fifo.sv
// Request queue holding {src,dst} pairs; pointers wrap modulo DEPTH, async clear.
module bus_req_fifo #(
  parameter int unsigned DATA_W = 6,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned PTR_W  = 2
) (
  input  logic              i_clk,
  input  logic              i_clr,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_data,
  output logic              o_full,
  output logic              o_empty
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W:0]    r_count;
  logic              w_push;
  logic              w_pop;

  assign o_full  = (r_count == (PTR_W+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_data  = r_mem[r_rd_ptr];

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_clr) begin
    if (i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/bus_transfer_controller.sv
// Bus initiator: queues "move src -> dst" requests and sequences each as DRIVE
// then LATCH, driving one-hot active-low enables so only one register drives.
module bus_transfer_controller
  import bus_transfer_controller_pkg::*;
#(
  parameter int unsigned NUM_REGS   = DEF_NUM_REGS,
  parameter int unsigned SEL_WIDTH  = DEF_SEL_WIDTH,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int unsigned PTR_WIDTH  = DEF_PTR_WIDTH
) (
  input logic                        i_CLOCK,
  input logic                        i_CLEAR,
  bus_transfer_controller_if.slave   bus
);

  localparam int unsigned REQ_W = 2 * SEL_WIDTH;

  xfer_state_t          r_state;
  logic [NUM_REGS-1:0]  r_write_n;
  logic [NUM_REGS-1:0]  r_read_n;
  logic [SEL_WIDTH-1:0] r_dst;
  logic                 r_done;
  logic                 r_error;
  logic                 r_err_pend;

  logic                 w_full;
  logic                 w_empty;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_head_ok;
  logic [REQ_W-1:0]     w_head;
  logic [SEL_WIDTH-1:0] w_head_src;
  logic [SEL_WIDTH-1:0] w_head_dst;

  function automatic logic [NUM_REGS-1:0] en_low(input logic [SEL_WIDTH-1:0] idx);
    return ~({{(NUM_REGS-1){1'b0}}, 1'b1} << idx);
  endfunction

  assign w_push = bus.i_REQ_VALID & ~w_full;

  bus_req_fifo #(
    .DATA_W (REQ_W),
    .DEPTH  (FIFO_DEPTH),
    .PTR_W  (PTR_WIDTH)
  ) u_req_fifo (
    .i_clk   (i_CLOCK),
    .i_clr   (i_CLEAR),
    .i_push  (w_push),
    .i_data  ({bus.i_REQ_SRC, bus.i_REQ_DST}),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_head_src = w_head[REQ_W-1:SEL_WIDTH];
  assign w_head_dst = w_head[SEL_WIDTH-1:0];
  assign w_head_ok  = ({1'b0, w_head_src} < (SEL_WIDTH+1)'(NUM_REGS)) &&
                      ({1'b0, w_head_dst} < (SEL_WIDTH+1)'(NUM_REGS)) &&
                      (w_head_src != w_head_dst);

  // A pending deferred error blocks the IDLE pop so two error pulses cannot collide.
  assign w_pop = ~w_empty &&
                 ((r_state == ST_LATCH) || ((r_state == ST_IDLE) && !r_err_pend));

  always_ff @(posedge i_CLOCK or posedge i_CLEAR) begin
    if (i_CLEAR) begin
      r_state    <= ST_IDLE;
      r_write_n  <= '1;
      r_read_n   <= '1;
      r_dst      <= '0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_err_pend <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_error    <= r_err_pend;
      r_err_pend <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            if (w_head_ok) begin
              r_state   <= ST_DRIVE;
              r_write_n <= en_low(w_head_src);
              r_dst     <= w_head_dst;
            end else begin
              r_error <= 1'b1;
            end
          end
        end
        ST_DRIVE: begin
          r_state  <= ST_LATCH;
          r_read_n <= en_low(r_dst);
        end
        ST_LATCH: begin
          r_done   <= 1'b1;
          r_read_n <= '1;
          if (w_pop && w_head_ok) begin
            r_state   <= ST_DRIVE;
            r_write_n <= en_low(w_head_src);
            r_dst     <= w_head_dst;
          end else begin
            // Invalid head popped here reports one cycle after this DONE.
            r_state    <= ST_IDLE;
            r_write_n  <= '1;
            r_err_pend <= w_pop;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_write_n <= '1;
          r_read_n  <= '1;
        end
      endcase
    end
  end

  assign bus.o_REQ_READY   = ~w_full;
  assign bus.o_WRITE_BUS_n = r_write_n;
  assign bus.o_READ_BUS_n  = r_read_n;
  assign bus.o_DONE        = r_done;
  assign bus.o_ERROR       = r_error;
  assign bus.o_BUSY        = ~w_empty | (r_state != ST_IDLE);

endmodule
